// File: rtl/sound_ram_arbiter.sv
// Shared sound RAM arbiter: main CPU (word) and Z80 (byte) onto one 16-bit
// synchronous RAM, three cycles per access (IDLE -> ACC -> CAP).
module sound_ram_arbiter #(
    parameter bit Z80_PRIORITY = 1'b0
) (
    input  logic        CLK_32M,
    input  logic        reset,
    input  logic        main_req,
    input  logic        main_we,
    input  logic [14:0] main_addr,
    input  logic [15:0] main_din,
    input  logic [1:0]  main_be,
    output logic [15:0] main_dout,
    output logic        main_ack,
    input  logic        z80_req,
    input  logic        z80_we,
    input  logic [15:0] z80_addr,
    input  logic [7:0]  z80_din,
    output logic [7:0]  z80_dout,
    output logic        z80_ack,
    output logic        z80_wait,
    output logic [14:0] ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we_h,
    output logic        ram_we_l,
    input  logic [15:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACC, CAP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_start;
    logic        w_main_el;
    logic        w_z80_el;
    logic        w_gnt_z80;
    logic        r_gnt_z80;
    logic        r_last_z80;
    logic        r_we;
    logic        r_a0;
    logic        r_main_ack;
    logic        r_z80_ack;
    logic [14:0] r_ram_addr;
    logic [15:0] r_ram_din;
    logic        r_we_h;
    logic        r_we_l;
    logic [15:0] r_main_dout;
    logic [7:0]  r_z80_dout;

    // A side being acked this cycle is not eligible, so a held request
    // is not re-granted on its own ack.
    assign w_main_el = main_req & ~r_main_ack;
    assign w_z80_el  = z80_req & ~r_z80_ack;
    assign w_gnt_z80 = w_z80_el & (~w_main_el | Z80_PRIORITY | ~r_last_z80);

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_main_el | w_z80_el) begin
                    w_next  = ACC;
                    w_start = 1'b1;
                end
            end
            ACC:     w_next = CAP;
            CAP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            r_gnt_z80   <= 1'b0;
            r_last_z80  <= 1'b1;
            r_we        <= 1'b0;
            r_a0        <= 1'b0;
            r_main_ack  <= 1'b0;
            r_z80_ack   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_we_h      <= 1'b0;
            r_we_l      <= 1'b0;
            r_main_dout <= '0;
            r_z80_dout  <= '0;
        end else begin
            r_we_h     <= 1'b0;
            r_we_l     <= 1'b0;
            r_main_ack <= 1'b0;
            r_z80_ack  <= 1'b0;
            if (w_start) begin
                r_gnt_z80  <= w_gnt_z80;
                r_last_z80 <= w_gnt_z80;
                if (w_gnt_z80) begin
                    r_we       <= z80_we;
                    r_a0       <= z80_addr[0];
                    r_ram_addr <= z80_addr[15:1];
                    r_ram_din  <= {z80_din, z80_din};
                    r_we_h     <= z80_we & z80_addr[0];
                    r_we_l     <= z80_we & ~z80_addr[0];
                end else begin
                    r_we       <= main_we;
                    r_a0       <= 1'b0;
                    r_ram_addr <= main_addr;
                    r_ram_din  <= main_din;
                    r_we_h     <= main_we & main_be[1];
                    r_we_l     <= main_we & main_be[0];
                end
            end
            if (r_state == CAP) begin
                if (r_gnt_z80) begin
                    r_z80_ack <= 1'b1;
                    if (!r_we) begin
                        r_z80_dout <= r_a0 ? ram_dout[15:8] : ram_dout[7:0];
                    end
                end else begin
                    r_main_ack <= 1'b1;
                    if (!r_we) begin
                        r_main_dout <= ram_dout;
                    end
                end
            end
        end
    end

    assign main_ack  = r_main_ack;
    assign z80_ack   = r_z80_ack;
    assign z80_wait  = z80_req & ~r_z80_ack;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_we_h  = r_we_h;
    assign ram_we_l  = r_we_l;
    assign main_dout = r_main_dout;
    assign z80_dout  = r_z80_dout;

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// Directed bench for sound_ram_arbiter: vector table of single accesses
// plus hand sequences for ties, dropped requests and reset mid-access.
module tb_sound_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        main_req;
    logic        main_we;
    logic [14:0] main_addr;
    logic [15:0] main_din;
    logic [1:0]  main_be;
    logic        z80_req;
    logic        z80_we;
    logic [15:0] z80_addr;
    logic [7:0]  z80_din;

    logic [15:0] main_dout0, main_dout1;
    logic        main_ack0, main_ack1;
    logic [7:0]  z80_dout0, z80_dout1;
    logic        z80_ack0, z80_ack1;
    logic        z80_wait0, z80_wait1;
    logic [14:0] ra0, ra1;
    logic [15:0] rdi0, rdi1;
    logic        weh0, weh1, wel0, wel1;
    logic [15:0] rdo0, rdo1;

    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];

    int n_vec;
    int n_bad;

    typedef struct {
        logic        z80;
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
        logic [1:0]  be;
        logic [14:0] e_addr;
        logic [15:0] e_rdin;
        logic        e_wh;
        logic        e_wl;
        logic [15:0] e_dout;
    } vec_t;

    vec_t tbl [13];

    sound_ram_arbiter #(.Z80_PRIORITY(1'b0)) dut0 (
        .CLK_32M(clk), .reset(rst),
        .main_req(main_req), .main_we(main_we), .main_addr(main_addr),
        .main_din(main_din), .main_be(main_be),
        .main_dout(main_dout0), .main_ack(main_ack0),
        .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr),
        .z80_din(z80_din), .z80_dout(z80_dout0), .z80_ack(z80_ack0),
        .z80_wait(z80_wait0),
        .ram_addr(ra0), .ram_din(rdi0), .ram_we_h(weh0), .ram_we_l(wel0),
        .ram_dout(rdo0)
    );

    sound_ram_arbiter #(.Z80_PRIORITY(1'b1)) dut1 (
        .CLK_32M(clk), .reset(rst),
        .main_req(main_req), .main_we(main_we), .main_addr(main_addr),
        .main_din(main_din), .main_be(main_be),
        .main_dout(main_dout1), .main_ack(main_ack1),
        .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr),
        .z80_din(z80_din), .z80_dout(z80_dout1), .z80_ack(z80_ack1),
        .z80_wait(z80_wait1),
        .ram_addr(ra1), .ram_din(rdi1), .ram_we_h(weh1), .ram_we_l(wel1),
        .ram_dout(rdo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-writable RAM with one-cycle read latency
    always @(posedge clk) begin
        if (weh0) mem0[ra0[7:0]][15:8] <= rdi0[15:8];
        if (wel0) mem0[ra0[7:0]][7:0]  <= rdi0[7:0];
        rdo0 <= mem0[ra0[7:0]];
        if (weh1) mem1[ra1[7:0]][15:8] <= rdi1[15:8];
        if (wel1) mem1[ra1[7:0]][7:0]  <= rdi1[7:0];
        rdo1 <= mem1[ra1[7:0]];
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        main_req = 1'b0;
        z80_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        @(negedge clk);
        if (v.z80) begin
            z80_req  = 1'b1;
            z80_we   = v.we;
            z80_addr = v.addr;
            z80_din  = v.din[7:0];
        end else begin
            main_req  = 1'b1;
            main_we   = v.we;
            main_addr = v.addr[14:0];
            main_din  = v.din;
            main_be   = v.be;
        end
        #1;
        chk({s, " wait_N"}, 16'(z80_wait0), 16'(v.z80));
        @(posedge clk);
        #1;
        main_addr = 15'h7FFF;
        main_din  = 16'hDEAD;
        main_be   = ~v.be;
        main_we   = ~v.we;
        z80_addr  = 16'hFFFF;
        z80_din   = 8'hC3;
        z80_we    = ~v.we;
        @(negedge clk);
        chk({s, " acc_addr"}, 16'(ra0), 16'(v.e_addr));
        chk({s, " acc_din"}, rdi0, v.e_rdin);
        chk({s, " acc_strobes"}, 16'({weh0, wel0}), 16'({v.e_wh, v.e_wl}));
        chk({s, " acc_acks"}, 16'({main_ack0, z80_ack0}), 16'h0);
        @(negedge clk);
        chk({s, " cap_strobes"}, 16'({weh0, wel0}), 16'h0);
        chk({s, " cap_addr_hold"}, 16'(ra0), 16'(v.e_addr));
        chk({s, " cap_wait"}, 16'(z80_wait0), 16'(v.z80));
        @(negedge clk);
        chk({s, " acks"}, 16'({main_ack0, z80_ack0}),
            v.z80 ? 16'h1 : 16'h2);
        chk({s, " wait_ack"}, 16'(z80_wait0), 16'h0);
        if (v.z80)
            chk({s, " z80_dout"}, 16'(z80_dout0), 16'(v.e_dout[7:0]));
        else
            chk({s, " main_dout"}, main_dout0, v.e_dout);
        main_req = 1'b0;
        z80_req  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        main_req = 1'b0; main_we = 1'b0; main_addr = '0;
        main_din = '0; main_be = '0;
        z80_req = 1'b0; z80_we = 1'b0; z80_addr = '0; z80_din = '0;

        tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 15'h0010, 16'hBEEF, 1'b1, 1'b1, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 15'h0010, 16'h0000, 1'b0, 1'b0, 16'h00BE};
        tbl[2]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 15'h0010, 16'h0000, 1'b0, 1'b0, 16'h00EF};
        tbl[3]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 2'b11, 15'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
        tbl[4]  = '{1'b0, 1'b1, 16'h0000, 16'h1234, 2'b11, 15'h0000, 16'h1234, 1'b1, 1'b1, 16'hBEEF};
        tbl[5]  = '{1'b1, 1'b1, 16'h0001, 16'h005A, 2'b00, 15'h0000, 16'h5A5A, 1'b1, 1'b0, 16'h00EF};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h5A34};
        tbl[7]  = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 2'b01, 15'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h5A34};
        tbl[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 2'b00, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h5A34};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h5AFF};
        tbl[10] = '{1'b1, 1'b1, 16'h0020, 16'h0077, 2'b00, 15'h0010, 16'h7777, 1'b0, 1'b1, 16'h00EF};
        tbl[11] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 15'h0010, 16'h0000, 1'b0, 1'b0, 16'h00BE};
        tbl[12] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 2'b11, 15'h0010, 16'h0000, 1'b0, 1'b0, 16'hBE77};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_acks", 16'({main_ack0, z80_ack0}), 16'h0);
        chk("rst_strobes", 16'({weh0, wel0}), 16'h0);
        chk("rst_addr", 16'(ra0), 16'h0);
        chk("rst_din", rdi0, 16'h0);
        chk("rst_main_dout", main_dout0, 16'h0);
        chk("rst_z80_dout", 16'(z80_dout0), 16'h0);
        chk("rst_wait", 16'(z80_wait0), 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run(tbl[i], i);

        @(negedge clk);
        chk("mem_word0", mem0[0], 16'h5AFF);
        chk("mem_word10", mem0[16], 16'hBE77);

        // Request dropped after one cycle still completes
        @(negedge clk);
        z80_req = 1'b1; z80_we = 1'b0; z80_addr = 16'h0020; z80_din = 8'h00;
        @(negedge clk);
        z80_req = 1'b0;
        @(negedge clk);
        chk("drop_wait", 16'(z80_wait0), 16'h0);
        @(negedge clk);
        chk("drop_ack", 16'({main_ack0, z80_ack0}), 16'h1);
        chk("drop_dout", 16'(z80_dout0), 16'h0077);

        // Reset asserted while a write is in ACC
        @(negedge clk);
        @(negedge clk);
        main_req = 1'b1; main_we = 1'b1; main_addr = 15'h0005;
        main_din = 16'hAAAA; main_be = 2'b11;
        @(negedge clk);
        chk("rstacc_pre", 16'({weh0, wel0}), 16'h3);
        #1;
        rst = 1'b1;
        #1;
        chk("rstacc_strobes", 16'({weh0, wel0}), 16'h0);
        chk("rstacc_addr", 16'(ra0), 16'h0);
        main_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstacc_noack", 16'({main_ack0, z80_ack0}), 16'h0);
        end
        chk("rstacc_mem", mem0[5], 16'h0000);
        run('{1'b0, 1'b1, 16'h0005, 16'hAAAA, 2'b11, 15'h0005, 16'hAAAA, 1'b1, 1'b1, 16'h0000}, 20);
        run('{1'b0, 1'b0, 16'h0005, 16'h0000, 2'b11, 15'h0005, 16'h0000, 1'b0, 1'b0, 16'hAAAA}, 21);

        // Simultaneous held requests after reset
        do_reset();
        main_we = 1'b0; main_addr = 15'h0010; main_be = 2'b11;
        z80_we = 1'b0; z80_addr = 16'h0020;
        main_req = 1'b1;
        z80_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            logic [1:0] e0;
            @(negedge clk);
            e0 = 2'b00;
            if (c == 3 || c == 9) e0 = 2'b10;
            if (c == 6 || c == 12) e0 = 2'b01;
            chk($sformatf("rr_c%0d", c), 16'({main_ack0, z80_ack0}), 16'(e0));
            chk($sformatf("prio_c%0d", c), 16'({main_ack1, z80_ack1}),
                16'({e0[0], e0[1]}));
        end
        main_req = 1'b0;
        z80_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sound_ram_arbiter.md
SOUND_RAM_ARBITER -- requirements
Module: sound_ram_arbiter

Interface
REQ-001 Parameter Z80_PRIORITY, default 0: 0 = round-robin arbitration, 1 = Z80 side always wins simultaneous requests.
REQ-002 CLK_32M  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 main_req  input  1  main CPU access request (SDBEN & (MRD|MWR)); level, held until main_ack.
REQ-005 main_we  input  1  1 = write, 0 = read; valid while main_req.
REQ-006 main_addr  input  15  word address (CPU A[15:1]).
REQ-007 main_din  input  16  write data.
REQ-008 main_be  input  2  byte enables; [1] = high byte, [0] = low byte.
REQ-009 main_dout  output  16  registered read data.
REQ-010 main_ack  output  1  one-cycle completion pulse.
REQ-011 z80_req  input  1  sound CPU request; level, held until z80_ack.
REQ-012 z80_we  input  1  1 = write.
REQ-013 z80_addr  input  16  byte address.
REQ-014 z80_din  input  8  write data.
REQ-015 z80_dout  output  8  registered read data.
REQ-016 z80_ack  output  1  one-cycle completion pulse.
REQ-017 z80_wait  output  1  combinational z80_req & ~z80_ack, drives the Z80 WAIT input.
REQ-018 ram_addr  output  15  shared RAM word address.
REQ-019 ram_din  output  16  shared RAM write data.
REQ-020 ram_we_h / ram_we_l  output  1 each  byte write strobes.
REQ-021 ram_dout  input  16  RAM read data, one-cycle synchronous latency.

Function
REQ-022 The FSM SHALL have states IDLE, ACC and CAP.
- IDLE: go to ACC when any eligible request is present, else stay in IDLE.
- ACC: go to CAP unconditionally.
- CAP: go to IDLE unconditionally.
REQ-023 In IDLE, a requester SHALL be eligible only if its req is high and its ack is low in that cycle, so a request is never re-granted while it is being acknowledged.
REQ-024 Simultaneous eligible requests with Z80_PRIORITY=0 SHALL be granted to the side not granted last; a lone request SHALL be granted immediately.
REQ-025 The grant and all request fields (we, addr, din, be) SHALL be latched on the IDLE->ACC edge; later input changes SHALL not affect the access in flight.
REQ-026 ACC SHALL drive ram_addr/ram_din from the latched request, with write strobes high for exactly this one cycle.
- Main: ram_addr = main_addr; ram_din = main_din; we_h = we & be[1]; we_l = we & be[0].
- Z80: ram_addr = z80_addr[15:1]; ram_din = {z80_din, z80_din}; we_h = we & addr[0]; we_l = we & ~addr[0].
REQ-027 Outside ACC, ram_we_h and ram_we_l SHALL be 0, and ram_addr SHALL hold its last value.
REQ-028 CAP SHALL capture ram_dout: main_dout <= ram_dout; z80_dout <= addr[0] ? ram_dout[15:8] : ram_dout[7:0]. It SHALL also set the granted side's ack register.
REQ-029 The ack SHALL be high for exactly one cycle, the cycle after CAP. Latency SHALL be request seen in IDLE at cycle N -> ack at N+3.
REQ-030 Writes SHALL also ack and SHALL leave the dout registers unchanged.
REQ-031 A main write with be=00 SHALL complete and ack with no RAM strobe.
REQ-032 A request dropped before its ack SHALL still complete its latched access.
REQ-033 Throughput SHALL be at most one access per 3 cycles. A continuously asserting pair SHALL alternate main/Z80 under round-robin.

Reset
REQ-034 Reset SHALL force the following, with any in-flight access abandoned without a RAM strobe:
- state = IDLE
- main_ack = z80_ack = 0
- ram_we_h = ram_we_l = 0
- ram_addr = 0, ram_din = 0
- main_dout = 0, z80_dout = 0
- last-grant = Z80, so main wins the first tie.

Verification
REQ-035 Main write 0xBEEF at word 0x0010 with be=11 -> ACC at N+1 with ram_addr=0x0010, we_h=we_l=1; main_ack at N+3; RAM holds 0xBEEF.
REQ-036 Z80 read of byte 0x0021 with RAM word 0x0010=0xBEEF -> z80_dout=0xBE and z80_ack at N+3; z80_wait high during cycles N..N+2.
REQ-037 Both requests raised in the same cycle after reset, held (re-raised after each ack) -> grants main, Z80, main, Z80 on successive acks; with Z80_PRIORITY=1 -> Z80 first.
REQ-038 Z80 write 0x5A at byte 0x0001 -> only ram_we_h asserted, ram_din=0x5A5A; low byte of the word unchanged.
REQ-039 Reset asserted during ACC -> strobes drop immediately; no ack; after release, a re-issued request completes normally.
